alu_result_demux: RTL and testbench
===================================

// Module: alu_result_demux
// PURPOSE
//  Registered 1:5 result distributor: the inverse of the 5:1 ALU result select mux.
//  Accepts one WIDTH-bit word plus a 3-bit ctl lane code per valid/ready transfer.
//  Steers the word into the addressed lane's one-entry holding register.
//  Each lane presents the word to its consumer with its own valid/ready handshake.
// PARAMETERS
//  WIDTH    32   data width of input word and every lane output
//  CNT_W    16   width of per-lane delivery counters (CNT_EN build only)
// PORTS
//  clk        in   1         rising-edge clock
//  rst_n      in   1         asynchronous active-low reset
//  in_valid   in   1         producer offers in_ctl/in_data
//  in_ready   out  1         block accepts this cycle (transfer = in_valid & in_ready)
//  in_ctl     in   3         destination lane 0..4; 5..7 illegal
//  in_data    in   WIDTH     word to route
//  out_valid  out  5         bit k: lane k holds a word
//  out_ready  in   5         bit k: lane k consumer takes word this cycle
//  out_data   out  5*WIDTH   lane k word on bits [k*WIDTH +: WIDTH]
//  err_ctl    out  1         sticky: an illegal in_ctl was accepted
//  lane_cnt   out  5*CNT_W   lane k delivery count (CNT_EN build only)
// BEHAVIOUR
//  Reset (rst_n low, async): out_valid=0, out_data=0, err_ctl=0, lane_cnt=0.
//   Reset mid-transfer discards held words; no partial state survives.
//  Lane k state: EMPTY (out_valid[k]=0) / FULL (out_valid[k]=1).
//   EMPTY -> FULL on input transfer with in_ctl==k.
//   FULL -> EMPTY on out_ready[k] with no new input to k.
//   FULL -> FULL on out_ready[k] and input to k same cycle (word replaced).
//  in_ready (combinational, no path from in_data):
//   ctl 0..4: ~out_valid[in_ctl] | out_ready[in_ctl].
//   ctl 5..7: 1 (word dropped, err_ctl set next edge).
//  Latency: accepted word visible on out_data lane next cycle; 1 word/cycle throughput.
//  out_data[k] changes only on a load into lane k; stable while FULL and not ready.
//  Lanes independent: drain on lane j never blocks input to lane k != j.
//  Order within one lane preserved; no cross-lane order guarantee.
//  in_valid low: no state change besides drains. out_ready on EMPTY lane ignored.
//  err_ctl cleared only by reset.
// CONFIGURATION
//  ALU_DEMUX_CNT_EN defined: lane_cnt present.
//   lane k counter increments on each out_valid[k]&out_ready[k].
//   Counter wraps modulo 2^CNT_W (all-ones -> 0, no saturation).
//  ALU_DEMUX_CNT_EN undefined: lane_cnt port and counters absent; all else identical.
// TESTING
//  Reset: rst_n=0 asynchronously mid-cycle with lanes FULL
//   -> out_valid=00000, err_ctl=0 immediately.
//  Single route: in_ctl=3, in_data=32'hDEADBEEF, out_ready=0
//   -> next cycle out_valid=01000, lane3 data DEADBEEF, in_ready=0 for ctl=3, 1 for ctl=1.
//  Back-to-back: lane2 FULL, out_ready[2]=1, in ctl=2 data=32'h5
//   -> in_ready=1, lane2 holds 5 next cycle, out_valid[2] stays 1.
//  Illegal ctl: in_ctl=6, in_valid=1 -> in_ready=1, out_valid unchanged, err_ctl=1 next cycle.
//  Stream: 5 words ctl 0..4, out_ready=11111 -> each lane delivers its word 1 cycle after accept.
//  CNT_EN: lane0 counter preloaded via 2^16-1 deliveries, one more -> lane_cnt[0]=0.

Source files
------------

// File: rtl/alu_result_demux.sv
// alu_result_demux: registered 1:5 result distributor.
// One WIDTH-bit word with a 3-bit lane code arrives per valid/ready transfer.
// The word is steered into the one-entry holding register of the addressed lane.
// Each lane then offers the word to its own consumer with a valid/ready handshake.
// Lane codes 5..7 are illegal: the word is accepted and dropped, and err_ctl sets
// and stays set until reset.
// Optional build macro: ALU_DEMUX_CNT_EN adds a per-lane delivery counter (lane_cnt).
module alu_result_demux #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_ctl,
    input  logic [WIDTH-1:0]     in_data,
    output logic [4:0]           out_valid,
    input  logic [4:0]           out_ready,
    output logic [5*WIDTH-1:0]   out_data,
    output logic                 err_ctl
`ifdef ALU_DEMUX_CNT_EN
    ,
    output logic [5*CNT_W-1:0]   lane_cnt
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } lane_state_t;

    lane_state_t      r_laneState [5];
    lane_state_t      w_stateNext [5];
    logic [WIDTH-1:0] r_laneData  [5];
    logic             r_errCtl;

    logic             w_legal;
    logic             w_xfer;
    logic [4:0]       w_load;
    logic [4:0]       w_drain;

    // Accept when the addressed lane is empty or drains this cycle; illegal codes always accept
    always_comb begin
        w_legal  = (in_ctl <= 3'd4);
        in_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (in_ctl == 3'(k)) begin
                in_ready = (r_laneState[k] == EMPTY) | out_ready[k];
            end
        end
    end

    // Per-lane load and drain strobes plus EMPTY/FULL next-state logic
    always_comb begin
        w_xfer = in_valid & in_ready;
        for (int k = 0; k < 5; k++) begin
            w_load[k]      = w_xfer & w_legal & (in_ctl == 3'(k));
            w_drain[k]     = (r_laneState[k] == FULL) & out_ready[k];
            w_stateNext[k] = r_laneState[k];
            case (r_laneState[k])
                EMPTY: begin
                    if (w_load[k]) begin
                        w_stateNext[k] = FULL;
                    end
                end
                FULL: begin
                    if (w_load[k]) begin
                        w_stateNext[k] = FULL;
                    end else if (w_drain[k]) begin
                        w_stateNext[k] = EMPTY;
                    end
                end
                default: w_stateNext[k] = EMPTY;
            endcase
        end
    end

    // Lane state registers; reset discards any held word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 5; k++) begin
                r_laneState[k] <= EMPTY;
            end
        end else begin
            for (int k = 0; k < 5; k++) begin
                r_laneState[k] <= w_stateNext[k];
            end
        end
    end

    // Holding registers change only when their own lane loads, so data is stable while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 5; k++) begin
                r_laneData[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 5; k++) begin
                if (w_load[k]) begin
                    r_laneData[k] <= in_data;
                end
            end
        end
    end

    // Sticky flag recording that an illegal lane code was accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_errCtl <= 1'b0;
        end else if (w_xfer && !w_legal) begin
            r_errCtl <= 1'b1;
        end
    end

    // Flatten lane state and data onto the output buses
    always_comb begin
        for (int k = 0; k < 5; k++) begin
            out_valid[k]              = (r_laneState[k] == FULL);
            out_data[k*WIDTH +: WIDTH] = r_laneData[k];
        end
        err_ctl = r_errCtl;
    end

`ifdef ALU_DEMUX_CNT_EN
    logic [CNT_W-1:0] r_laneCnt [5];

    // Delivery counters step on each completed lane handshake and wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 5; k++) begin
                r_laneCnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 5; k++) begin
                if (w_drain[k]) begin
                    r_laneCnt[k] <= r_laneCnt[k] + 1'b1;
                end
            end
        end
    end

    // Flatten the counters onto the lane_cnt bus
    always_comb begin
        for (int k = 0; k < 5; k++) begin
            lane_cnt[k*CNT_W +: CNT_W] = r_laneCnt[k];
        end
    end
`endif

endmodule

// File: tb/tb_alu_result_demux.sv
// Self-checking bench for alu_result_demux.
// Directed vectors push their expected lane words into per-lane queues; an
// independent monitor compares every presented lane word against its queue.
module tb_alu_result_demux;

    localparam int WIDTH = 32;
    localparam int CNT_W = 16;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [2:0]         in_ctl;
    logic [WIDTH-1:0]   in_data;
    logic [4:0]         out_valid;
    logic [4:0]         out_ready;
    logic [5*WIDTH-1:0] out_data;
    logic               err_ctl;
`ifdef ALU_DEMUX_CNT_EN
    logic [5*CNT_W-1:0] lane_cnt;
`endif

    int vecCount  = 0;
    int missCount = 0;

    logic [WIDTH-1:0] expQ [5][$];

    alu_result_demux #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctl    (in_ctl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err_ctl   (err_ctl)
`ifdef ALU_DEMUX_CNT_EN
        ,
        .lane_cnt  (lane_cnt)
`endif
    );

    // Free-running clock, 10 time units per cycle
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run can never hang
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // One cycle of stimulus: drive after the edge, check in_ready mid-cycle, record expected word
    task automatic applyStimulus(input logic v, input logic [2:0] ctl, input logic [WIDTH-1:0] data,
                                 input logic [4:0] rdy, input logic expReady);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_ctl    = ctl;
        in_data   = data;
        out_ready = rdy;
        @(negedge clk);
        checkOutput("in_ready", {31'b0, in_ready}, {31'b0, expReady});
        if (v && expReady && ctl <= 3'd4) begin
            expQ[ctl].push_back(data);
        end
    endtask

    task automatic clearQueues();
        for (int k = 0; k < 5; k++) begin
            expQ[k].delete();
        end
    endtask

    // Monitor: any presented lane word must match the head of that lane's queue
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 5; k++) begin
                if (out_valid[k]) begin
                    if (expQ[k].size() == 0) begin
                        vecCount++;
                        missCount++;
                        $display("[TB] FAIL lane%0d_unexpected: got valid data %h required no word", k,
                                 out_data[k*WIDTH +: WIDTH]);
                    end else begin
                        checkOutput($sformatf("lane%0d_data", k), out_data[k*WIDTH +: WIDTH], expQ[k][0]);
                        if (out_ready[k]) begin
                            void'(expQ[k].pop_front());
                        end
                    end
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_ctl    = 3'd0;
        in_data   = '0;
        out_ready = 5'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        checkOutput("reset_out_valid", {27'b0, out_valid}, 32'h0);
        checkOutput("reset_err_ctl", {31'b0, err_ctl}, 32'h0);
        checkOutput("reset_out_data", out_data[31:0], 32'h0);

        // Single route to lane 3; afterwards lane 3 stalls and lane 1 stays open
        applyStimulus(1'b1, 3'd3, 32'hDEADBEEF, 5'b00000, 1'b1);
        applyStimulus(1'b0, 3'd3, 32'h0, 5'b00000, 1'b0);
        checkOutput("route_out_valid", {27'b0, out_valid}, 32'h08);
        applyStimulus(1'b0, 3'd1, 32'h0, 5'b00000, 1'b1);

        // Back-to-back on lane 2: drain and reload in one cycle
        applyStimulus(1'b1, 3'd2, 32'h22, 5'b00000, 1'b1);
        applyStimulus(1'b1, 3'd2, 32'h5, 5'b00100, 1'b1);
        applyStimulus(1'b0, 3'd0, 32'h0, 5'b00000, 1'b1);
        checkOutput("b2b_out_valid", {27'b0, out_valid}, 32'h0C);

        // Illegal lane code is accepted, dropped and flagged
        applyStimulus(1'b1, 3'd6, 32'hBAD0BAD0, 5'b00000, 1'b1);
        applyStimulus(1'b0, 3'd0, 32'h0, 5'b00000, 1'b1);
        checkOutput("illegal_out_valid", {27'b0, out_valid}, 32'h0C);
        checkOutput("illegal_err_ctl", {31'b0, err_ctl}, 32'h1);
        applyStimulus(1'b0, 3'd7, 32'h0, 5'b00000, 1'b1);

        // Drain everything
        applyStimulus(1'b0, 3'd0, 32'h0, 5'b11111, 1'b1);
        applyStimulus(1'b0, 3'd0, 32'h0, 5'b11111, 1'b1);
        checkOutput("drain_out_valid", {27'b0, out_valid}, 32'h0);

        // Stream one word to each lane with all consumers ready
        applyStimulus(1'b1, 3'd0, 32'hA0A0A0A0, 5'b11111, 1'b1);
        applyStimulus(1'b1, 3'd1, 32'hB1B1B1B1, 5'b11111, 1'b1);
        checkOutput("stream_lane0_valid", {27'b0, out_valid}, 32'h01);
        applyStimulus(1'b1, 3'd2, 32'hC2C2C2C2, 5'b11111, 1'b1);
        applyStimulus(1'b1, 3'd3, 32'hD3D3D3D3, 5'b11111, 1'b1);
        applyStimulus(1'b1, 3'd4, 32'hE4E4E4E4, 5'b11111, 1'b1);
        applyStimulus(1'b0, 3'd0, 32'h0, 5'b11111, 1'b1);
        checkOutput("stream_lane4_valid", {27'b0, out_valid}, 32'h10);
        applyStimulus(1'b0, 3'd0, 32'h0, 5'b11111, 1'b1);
        checkOutput("stream_empty", {27'b0, out_valid}, 32'h0);

        // Lane independence: stalled lane 1 does not block lane 4
        applyStimulus(1'b1, 3'd1, 32'h11111111, 5'b00000, 1'b1);
        applyStimulus(1'b1, 3'd4, 32'h44444444, 5'b00000, 1'b1);
        applyStimulus(1'b1, 3'd1, 32'h99999999, 5'b10000, 1'b0);
        applyStimulus(1'b0, 3'd0, 32'h0, 5'b00000, 1'b1);
        checkOutput("indep_out_valid", {27'b0, out_valid}, 32'h02);
        checkOutput("indep_err_sticky", {31'b0, err_ctl}, 32'h1);

        // Asynchronous reset mid-cycle with a lane full
        applyStimulus(1'b1, 3'd4, 32'h12345678, 5'b00000, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_out_valid", {27'b0, out_valid}, 32'h0);
        checkOutput("async_rst_err_ctl", {31'b0, err_ctl}, 32'h0);
        clearQueues();
        @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(1'b0, 3'd1, 32'h0, 5'b00000, 1'b1);
        checkOutput("post_rst_out_valid", {27'b0, out_valid}, 32'h0);

`ifdef ALU_DEMUX_CNT_EN
        // Lane 0 counter wraps: 65535 deliveries, then one more
        for (int i = 0; i < 65536; i++) begin
            applyStimulus(1'b1, 3'd0, WIDTH'(i), 5'b00001, 1'b1);
        end
        applyStimulus(1'b0, 3'd0, 32'h0, 5'b00001, 1'b1);
        checkOutput("cnt_lane0_full", {16'b0, lane_cnt[15:0]}, 32'h0000FFFF);
        applyStimulus(1'b0, 3'd0, 32'h0, 5'b00000, 1'b1);
        checkOutput("cnt_lane0_wrap", {16'b0, lane_cnt[15:0]}, 32'h0);
        checkOutput("cnt_lane1", {16'b0, lane_cnt[31:16]}, 32'h0);
`endif

        // Every expected word must have been delivered
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("lane%0d_leftover", k), expQ[k].size(), 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
